// File: rtl/fphub_div_arbiter.sv
// Two-channel round-robin front end that serialises HUB divide requests onto one shared divider.
// Define FPHUB_DIV_ARB_TIMEOUT_EN to add a watchdog that aborts a divide after TIMEOUT busy cycles.
module fphub_div_arbiter #(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [M+E:0]   req0_x,
    input  logic [M+E:0]   req0_d,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [M+E:0]   req1_x,
    input  logic [M+E:0]   req1_d,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [M+E:0]   rsp_data,
    output logic           rsp_ch,
    output logic           rsp_err,
    output logic           div_start,
    output logic [M+E:0]   div_x,
    output logic [M+E:0]   div_d,
    input  logic [M+E:0]   div_res,
    input  logic           div_finish,
    output logic           busy,
    output logic [15:0]    op_count
);
    localparam int W = M + E + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic           ch_q, ch_d;
    logic [W-1:0]   opx_q, opx_d;
    logic [W-1:0]   opd_q, opd_d;
    logic [W-1:0]   res_q, res_d;
    logic [15:0]    op_count_q, op_count_d;
    logic           gnt_ch_s;
    logic           rdy0_s, rdy1_s;

`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
`endif

    // Contention goes to rr; a lone requester always wins.
    assign gnt_ch_s = (req0_valid && req1_valid) ? rr_q : !req0_valid;

    // Next-state, grant and capture logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        ch_d       = ch_q;
        opx_d      = opx_q;
        opd_d      = opd_q;
        res_d      = res_q;
        op_count_d = op_count_q;
        rdy0_s     = 1'b0;
        rdy1_s     = 1'b0;
`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    rdy0_s  = !gnt_ch_s;
                    rdy1_s  = gnt_ch_s;
                    ch_d    = gnt_ch_s;
                    rr_d    = !gnt_ch_s;
                    opx_d   = gnt_ch_s ? req1_x : req0_x;
                    opd_d   = gnt_ch_s ? req1_d : req0_d;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = BUSY;
`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
                wdog_d  = {WDW{1'b0}};
`endif
            end
            BUSY: begin
                if (div_finish) begin
                    res_d   = div_res;
                    state_d = RESP;
`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    res_d   = {W{1'b0}};
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d  = wdog_q + WDW'(1);
                end
`else
                end else begin
                    state_d = BUSY;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    state_d    = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            ch_q       <= 1'b0;
            opx_q      <= {W{1'b0}};
            opd_q      <= {W{1'b0}};
            res_q      <= {W{1'b0}};
            op_count_q <= 16'd0;
`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
            wdog_q     <= {WDW{1'b0}};
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            ch_q       <= ch_d;
            opx_q      <= opx_d;
            opd_q      <= opd_d;
            res_q      <= res_d;
            op_count_q <= op_count_d;
`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    // Ready is qualified by rst_l so a held request cannot see a grant while reset is asserted.
    assign req0_ready = rdy0_s && rst_l;
    assign req1_ready = rdy1_s && rst_l;
    assign div_start  = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = res_q;
    assign rsp_ch     = ch_q;
    assign div_x      = opx_q;
    assign div_d      = opd_q;
    assign op_count   = op_count_q;

`ifdef FPHUB_DIV_ARB_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    // No abort path exists without the watchdog; TIMEOUT is referenced only to keep it elaborated.
    assign rsp_err = (TIMEOUT < 0);
`endif
endmodule

// File: doc/fphub_div_arbiter.md
FPHUB_DIV_ARBITER -- requirements
Module: fphub_div_arbiter

Interface
REQ-001 SHALL have parameters:
- M, 23, mantissa width.
- E, 8, exponent width.
- TIMEOUT, 64, watchdog limit in cycles; used only when FPHUB_DIV_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have ports, with W = M+E+1:
- clk  in  1  single clock; all state on rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  channel request valid.
- req0_ready / req1_ready  out  1  channel request accepted.
- req0_x, req0_d / req1_x, req1_d  in  W  HUB dividend and divisor.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  W  HUB quotient.
- rsp_ch  out  1  originating channel.
- rsp_err  out  1  watchdog abort flag.
- div_start  out  1  divider start pulse.
- div_x, div_d  out  W  divider operands.
- div_res  in  W  divider result.
- div_finish  in  1  divider completion pulse.
- busy  out  1  operation in flight.
- op_count  out  16  completed-response counter.

Function
REQ-003 SHALL implement FSM states IDLE, START, BUSY, RESP; busy = (state != IDLE).
REQ-004 IDLE: if either reqN_valid=1, SHALL grant one channel, drive its reqN_ready=1 for exactly that cycle, capture its x/d into operand registers and its index into rsp_ch, then go to START.
REQ-005 reqN_ready SHALL be 0 in every state except the IDLE grant cycle; at most one ready high per cycle.
REQ-006 Arbitration SHALL be round-robin. Pointer rr (reset 0) selects the winner when both channels are valid. After each grant, rr SHALL point to the non-granted channel.
REQ-007 START: div_start=1 for exactly one cycle, then go to BUSY; div_start SHALL be 0 in all other states.
REQ-008 div_x/div_d SHALL be driven from the operand registers and held stable from START until leaving BUSY.
REQ-009 BUSY: when div_finish=1, SHALL register div_res into rsp_data, set rsp_err=0 and go to RESP.
REQ-010 div_finish SHALL be ignored outside BUSY.
REQ-011 RESP: rsp_valid=1. rsp_data, rsp_ch and rsp_err SHALL hold stable until rsp_valid&&rsp_ready. On that handshake: go to IDLE and increment op_count.
REQ-012 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-013 Latency: accept edge -> div_start high the next cycle; rsp_valid high the cycle after div_finish is sampled. A divider finish in the first BUSY cycle (special-case path) SHALL be handled correctly.
REQ-014 A request arriving while busy=1 SHALL wait with ready=0 and is not dropped. The requester holds valid and operands until accepted.

Reset
REQ-015 rst_l=0 SHALL immediately force state=IDLE, rr=0, and all outputs to 0: ready, div_start, div_x, div_d, rsp_valid, rsp_data, rsp_ch, rsp_err, busy, op_count.
REQ-016 Reset mid-operation SHALL abandon the in-flight request with no response. The divider shares rst_l.

Configuration
REQ-017 With FPHUB_DIV_ARB_TIMEOUT_EN defined:
- A watchdog counter SHALL clear on entering BUSY and increment each BUSY cycle.
- If it reaches TIMEOUT without div_finish, SHALL set rsp_data=0 and rsp_err=1, and go to RESP.
REQ-018 Without FPHUB_DIV_ARB_TIMEOUT_EN: no watchdog logic, rsp_err tied 0, BUSY waits indefinitely for div_finish.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Only req0 valid, x=0x40400000, d=0x3F800000; divider model finishes after 32 cycles with 0x40400000 -> single div_start pulse; rsp_valid with rsp_data=0x40400000, rsp_ch=0, op_count=1.
- After reset, req0 and req1 valid in the same cycle -> ch0 served first, then ch1. The next simultaneous pair -> ch0 granted first again, since rr=0 after ch1's grant.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_data, rsp_ch stable; both ready stay 0; no div_start.
- div_finish pulsed while IDLE, then a finish one cycle after div_start -> no spurious response from the IDLE pulse; the early finish yields a response.
- Macro defined, TIMEOUT=16, divider never finishes -> rsp_valid with rsp_err=1 and rsp_data=0 after 16 BUSY cycles. Macro undefined -> busy stays 1.
- rst_l asserted during BUSY, and op_count preset to 0xFFFF then one handshake -> reset makes all outputs 0 asynchronously; the handshake wraps op_count to 0x0000.
